// File: rtl/execute_div.sv
// Multi-cycle restoring radix-2 divider (DIV/DIVU), one quotient bit per cycle plus a sign-fix cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iteration and goes straight to the fix cycle.
module execute_div #(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               valid,
   input  logic               is_signed,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               done,
   output logic [2*WIDTH-1:0] c
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, DOING, FIX} state_t;

   state_t           state, state_next;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] rem, quo, ub, ua;
   logic             neg_q, neg_r;
   logic             accept, zero_fast;
   logic [WIDTH:0]   rem_sh;
   logic             ge;
   logic [WIDTH-1:0] rem_step, quo_step;

   function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x, input logic en);
      return (en && x[WIDTH-1]) ? -x : x;
   endfunction

   function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] x, input logic neg);
      return neg ? -x : x;
   endfunction

   assign accept = (state == IDLE) && valid;
   assign ua     = abs_val(a, is_signed);
   assign done   = (state == IDLE);

`ifdef DIV_ZERO_FAST_EN
   assign zero_fast = (b == '0);
`else
   assign zero_fast = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (valid) state_next = zero_fast ? FIX : DOING;
         DOING:   if (count == CW'(1)) state_next = FIX;
         FIX:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Remainder never exceeds ub after a step, so the subtract fits in WIDTH bits.
   always_comb begin
      rem_sh   = {rem, quo[WIDTH-1]};
      ge       = rem_sh >= {1'b0, ub};
      rem_step = ge ? (rem_sh[WIDTH-1:0] - ub) : rem_sh[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], ge};
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         ub    <= abs_val(b, is_signed);
         neg_q <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
         neg_r <= is_signed & a[WIDTH-1];
         count <= CW'(WIDTH);
         if (zero_fast) begin
            rem <= ua;
            quo <= '1;
         end else begin
            rem <= '0;
            quo <= ua;
         end
      end else if (state == DOING) begin
         rem   <= rem_step;
         quo   <= quo_step;
         count <= count - CW'(1);
      end
   end

   // Only the fix edge publishes a result; a reset before it leaves c cleared.
   always_ff @(posedge clk) begin
      if (!resetn)            c <= '0;
      else if (state == FIX)  c <= {sign_fix(rem, neg_r), sign_fix(quo, neg_q)};
   end

endmodule

// File: tb/tb_execute_div.sv
// Bench for execute_div: directed vector table, multi-cycle corner sequences, and random ops
// checked against a plain-arithmetic reference model.
module tb_execute_div;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        done;
   logic [63:0] c;

   int compared = 0;
   int mismatched = 0;

   typedef struct {
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp;
   } vec_t;

   vec_t vecs[10];

   always #5 clk = ~clk;

   execute_div #(.WIDTH(32)) dut (
      .clk(clk), .resetn(resetn), .valid(valid), .is_signed(is_signed),
      .a(a), .b(b), .done(done), .c(c)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Truncating division on 64-bit values gives the architectural quotient/remainder directly.
   function automatic logic [63:0] model(input bit s, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, q, r;
      if (y == 32'h0) return {x, (s && x[31]) ? 32'h1 : 32'hFFFF_FFFF};
      if (!s) return {x % y, x / y};
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      q = sx / sy;
      r = sx % sy;
      return {r[31:0], q[31:0]};
   endfunction

   task automatic run_op(input bit s, input logic [31:0] aa, input logic [31:0] bb,
                         output logic [63:0] res, output int lat);
      is_signed = s; a = aa; b = bb; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      res = c;
   endtask

   task automatic run_check(input string name, input bit s, input logic [31:0] aa,
                            input logic [31:0] bb, input logic [63:0] exp);
      logic [63:0] res;
      int lat, expl;
      run_op(s, aa, bb, res, lat);
`ifdef DIV_ZERO_FAST_EN
      expl = (bb == 32'h0) ? 2 : 34;
`else
      expl = 34;
`endif
      check({name, "_lat"}, 64'(lat), 64'(expl));
      check(name, res, exp);
   endtask

   initial begin
      logic [63:0] res;
      int lat;
      bit stayed;
      bit s;
      logic [31:0] ra, rb;

      vecs[0] = '{1'b0, 32'd100,        32'd7,          {32'd2, 32'd14}};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          {32'hFFFF_FFFF, 32'hFFFF_FFFD}};
      vecs[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  {32'd1, 32'hFFFF_FFFD}};
      vecs[3] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  {32'h0, 32'h8000_0000}};
      vecs[4] = '{1'b0, 32'd5,          32'd0,          {32'd5, 32'hFFFF_FFFF}};
      vecs[5] = '{1'b1, 32'hFFFF_FFFB,  32'd0,          {32'hFFFF_FFFB, 32'h1}};
      vecs[6] = '{1'b1, 32'd7,          32'd0,          {32'd7, 32'hFFFF_FFFF}};
      vecs[7] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          {32'd0, 32'hFFFF_FFFF}};
      vecs[8] = '{1'b0, 32'd3,          32'd5,          {32'd3, 32'd0}};
      vecs[9] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  {32'hFFFF_FFFE, 32'd14}};

      repeat (3) @(posedge clk);
      #1;
      check("reset_done", 64'(done), 64'd1);
      check("reset_c", c, 64'd0);
      resetn = 1'b1;
      @(posedge clk); #1;
      check("idle_done", 64'(done), 64'd1);

      foreach (vecs[i]) run_check($sformatf("vec%0d", i), vecs[i].s, vecs[i].a, vecs[i].b, vecs[i].exp);

      // Back-to-back: second start in the first done-high cycle; old result held until its fix edge.
      run_check("b2b_first", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14});
      is_signed = 1'b0; a = 32'd9; b = 32'd2; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      check("b2b_busy", 64'(done), 64'd0);
      check("b2b_hold", c, {32'd2, 32'd14});
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("b2b_lat", 64'(lat), 64'd34);
      check("b2b_second", c, {32'd1, 32'd4});

      // Operand changes and a valid pulse while busy are ignored.
      is_signed = 1'b0; a = 32'd1000; b = 32'd9; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      lat = 1;
      while (done !== 1'b1 && lat < 100) begin
         if (lat == 5) begin
            a = 32'd50; b = 32'd3; is_signed = 1'b1; valid = 1'b1;
         end else begin
            valid = 1'b0;
         end
         @(posedge clk); #1;
         lat++;
      end
      valid = 1'b0;
      check("busy_lat", 64'(lat), 64'd34);
      check("busy_result", c, {32'd1, 32'd111});
      stayed = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
         if (done !== 1'b1) stayed = 1'b0;
      end
      check("busy_single_completion", 64'(stayed), 64'd1);

      // Reset mid-operation aborts without publishing a result.
      is_signed = 1'b0; a = 32'hFFFF_FFFF; b = 32'd3; valid = 1'b1;
      @(posedge clk); #1;
      valid = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      check("abort_busy", 64'(done), 64'd0);
      resetn = 1'b0;
      @(posedge clk); #1;
      check("abort_done", 64'(done), 64'd1);
      check("abort_c", c, 64'd0);
      resetn = 1'b1;
      run_check("after_abort", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3});

      for (int i = 0; i < 40; i++) begin
         s  = 1'($urandom_range(0, 1));
         ra = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = 32'h0;
            1:       rb = 32'($urandom_range(1, 15));
            2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
            default: rb = $urandom;
         endcase
         run_check($sformatf("rand%0d", i), s, ra, rb, model(s, ra, rb));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
